decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/mips_pkg.sv | 86 ++++++++
 rtl/reg_file.sv | 39 +++
 rtl/decode_stage.sv | 155 +++++++++++++++
 tb/tb_decode_stage.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, control bundle and decode helpers.
// Used by decode_stage and its register file.
package mips_pkg;

  localparam int REG_COUNT = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [1:0] {
    DEST_NONE,
    DEST_RT,
    DEST_RD
  } dest_sel_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       illegal;
    logic       is_end;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.reg_write = 1'b1;
        c.alu_op    = ALU_FUNCT;
      end
      OP_LW: begin
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.alu_src    = 1'b1;
        c.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      OP_HALT: c.is_end = 1'b1;
      // Unknown opcodes travel down the pipe as a flagged NOP.
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  function automatic dest_sel_e dest_select(input logic [5:0] op);
    dest_sel_e d;
    case (op)
      OP_RTYPE:        d = DEST_RD;
      OP_LW, OP_ADDI:  d = DEST_RT;
      default:         d = DEST_NONE;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port; register 0 is hard-wired to zero.
module reg_file
  import mips_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_start,
  input  logic        i_wr_en,
  input  logic [4:0]  i_wr_addr,
  input  logic [31:0] i_wr_data,
  input  logic [4:0]  i_rd_addr0,
  input  logic [4:0]  i_rd_addr1,
  output logic [31:0] o_rd_data0,
  output logic [31:0] o_rd_data1
);

  logic [31:0] w_regs [REG_COUNT];

  assign w_regs[0] = '0;

  genvar gi;
  for (gi = 1; gi < REG_COUNT; gi++) begin : g_reg
    logic [31:0] r_q;

    always_ff @(posedge i_clock or posedge i_start) begin
      if (i_start) begin
        r_q <= '0;
      end else if (i_wr_en && (i_wr_addr == 5'(gi))) begin
        r_q <= i_wr_data;
      end
    end

    assign w_regs[gi] = r_q;
  end

  assign o_rd_data0 = w_regs[i_rd_addr0];
  assign o_rd_data1 = w_regs[i_rd_addr1];

endmodule

// File: rtl/decode_stage.sv
// MIPS decode stage: valid/ready in and out, load-use stall, halt latch.
// Define WB_BYPASS_EN to forward same-cycle writeback data into operands.
module decode_stage
  import mips_pkg::*;
#(
  parameter int PC_W = 4
) (
  input  logic            clock,
  input  logic            start,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [PC_W-1:0] if_pc,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [31:0]     wb_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [PC_W-1:0] id_pc,
  output logic [31:0]     id_rs_data,
  output logic [31:0]     id_rt_data,
  output logic [31:0]     id_imm,
  output logic [4:0]      id_shamt,
  output logic [5:0]      id_funct,
  output logic [4:0]      id_dest,
  output logic            id_reg_write,
  output logic            id_mem_read,
  output logic            id_mem_write,
  output logic            id_mem_to_reg,
  output logic            id_branch,
  output logic            id_alu_src,
  output logic [1:0]      id_alu_op,
  output logic            id_illegal,
  output logic            id_end
);

  logic [5:0]  w_opcode;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  ctrl_t       w_ctrl;
  logic [4:0]  w_dest;
  logic [4:0]  w_src_idx  [2];
  logic [31:0] w_rf_data  [2];
  logic [31:0] w_src_data [2];
  logic        w_hazard;
  logic        w_accept;

  logic            r_valid;
  logic            r_halted;
  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_rs_data;
  logic [31:0]     r_rt_data;
  logic [31:0]     r_imm;
  logic [4:0]      r_shamt;
  logic [5:0]      r_funct;
  logic [4:0]      r_dest;
  ctrl_t           r_ctrl;

  assign w_opcode     = if_instr[31:26];
  assign w_rs         = if_instr[25:21];
  assign w_rt         = if_instr[20:16];
  assign w_rd         = if_instr[15:11];
  assign w_src_idx[0] = w_rs;
  assign w_src_idx[1] = w_rt;

  reg_file u_reg_file (
    .i_clock    (clock),
    .i_start    (start),
    .i_wr_en    (wb_en),
    .i_wr_addr  (wb_addr),
    .i_wr_data  (wb_data),
    .i_rd_addr0 (w_src_idx[0]),
    .i_rd_addr1 (w_src_idx[1]),
    .o_rd_data0 (w_rf_data[0]),
    .o_rd_data1 (w_rf_data[1])
  );

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_src
`ifdef WB_BYPASS_EN
    assign w_src_data[gi] = (wb_en && (wb_addr == w_src_idx[gi]) && (w_src_idx[gi] != 5'd0))
                            ? wb_data : w_rf_data[gi];
`else
    assign w_src_data[gi] = w_rf_data[gi];
`endif
  end

  always_comb begin
    w_ctrl = decode_ctrl(w_opcode);
    w_dest = 5'd0;
    case (dest_select(w_opcode))
      DEST_RT: w_dest = w_rt;
      DEST_RD: w_dest = w_rd;
      default: w_dest = 5'd0;
    endcase
  end

  // Load-use: the loaded value is not available until after execute/memory.
  always_comb begin
    w_hazard = r_valid && r_ctrl.mem_read && (r_dest != 5'd0)
               && ((w_rs == r_dest) || (w_rt == r_dest));
    if_ready = (!r_valid || id_ready) && !r_halted && !w_hazard && !start;
    w_accept = if_valid && if_ready;
  end

  always_ff @(posedge clock or posedge start) begin
    if (start) begin
      r_valid   <= 1'b0;
      r_halted  <= 1'b0;
      r_pc      <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_shamt   <= '0;
      r_funct   <= '0;
      r_dest    <= '0;
      r_ctrl    <= '0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_pc      <= if_pc;
      r_rs_data <= w_src_data[0];
      r_rt_data <= w_src_data[1];
      r_imm     <= sign_ext16(if_instr[15:0]);
      r_shamt   <= if_instr[10:6];
      r_funct   <= if_instr[5:0];
      r_dest    <= w_dest;
      r_ctrl    <= w_ctrl;
      if (w_ctrl.is_end) begin
        r_halted <= 1'b1;
      end
    end else if (id_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign id_valid      = r_valid;
  assign id_pc         = r_pc;
  assign id_rs_data    = r_rs_data;
  assign id_rt_data    = r_rt_data;
  assign id_imm        = r_imm;
  assign id_shamt      = r_shamt;
  assign id_funct      = r_funct;
  assign id_dest       = r_dest;
  assign id_reg_write  = r_ctrl.reg_write;
  assign id_mem_read   = r_ctrl.mem_read;
  assign id_mem_write  = r_ctrl.mem_write;
  assign id_mem_to_reg = r_ctrl.mem_to_reg;
  assign id_branch     = r_ctrl.branch;
  assign id_alu_src    = r_ctrl.alu_src;
  assign id_alu_op     = r_ctrl.alu_op;
  assign id_illegal    = r_ctrl.illegal;
  assign id_end        = r_ctrl.is_end;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized
// run against a behavioural model of the decode/stall rules.
module tb_decode_stage;

  typedef struct packed {
    logic        valid;
    logic [3:0]  pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [4:0]  dest;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        branch;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic        illegal;
    logic        is_end;
  } out_t;

  logic        clock = 1'b0;
  logic        start = 1'b1;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic [31:0] if_instr = '0;
  logic [3:0]  if_pc = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [3:0]  id_pc;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt;
  logic [5:0]  id_funct;
  logic [4:0]  id_dest;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        id_branch, id_alu_src, id_illegal, id_end;
  logic [1:0]  id_alu_op;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_regs [32];

  always #5 clock = ~clock;

  decode_stage #(.PC_W(4)) dut (
    .clock(clock), .start(start),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_funct(id_funct), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch), .id_alu_src(id_alu_src),
    .id_alu_op(id_alu_op), .id_illegal(id_illegal), .id_end(id_end)
  );

  function automatic out_t obs();
    return {id_valid, id_pc, id_rs_data, id_rt_data, id_imm, id_shamt, id_funct, id_dest,
            id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch, id_alu_src,
            id_alu_op, id_illegal, id_end};
  endfunction

  // Expected output register contents for an accepted instruction.
  function automatic out_t model(input logic [31:0] ins, input logic [3:0] pc,
                                 input logic [31:0] a, input logic [31:0] b);
    out_t e;
    e = '0;
    e.valid   = 1'b1;
    e.pc      = pc;
    e.rs_data = a;
    e.rt_data = b;
    e.imm     = {{16{ins[15]}}, ins[15:0]};
    e.shamt   = ins[10:6];
    e.funct   = ins[5:0];
    case (ins[31:26])
      6'h00: begin e.reg_write = 1; e.alu_op = 2'b10; e.dest = ins[15:11]; end
      6'h23: begin e.reg_write = 1; e.mem_read = 1; e.mem_to_reg = 1; e.alu_src = 1; e.dest = ins[20:16]; end
      6'h2B: begin e.mem_write = 1; e.alu_src = 1; end
      6'h04: begin e.branch = 1; e.alu_op = 2'b01; end
      6'h08: begin e.reg_write = 1; e.alu_src = 1; e.dest = ins[20:16]; end
      6'h3F: e.is_end = 1;
      default: e.illegal = 1;
    endcase
    return e;
  endfunction

  // Operand value seen in the capture cycle, given the writeback inputs now driven.
  function automatic logic [31:0] src(input logic [4:0] idx);
`ifdef WB_BYPASS_EN
    if (wb_en && wb_addr == idx && idx != 5'd0) return wb_data;
`endif
    return (idx == 5'd0) ? 32'd0 : m_regs[idx];
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [3:0] pc,
                       input logic rdy, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd);
    if_valid = v; if_instr = ins; if_pc = pc; id_ready = rdy;
    wb_en = we; wb_addr = wa; wb_data = wd;
  endtask

  task automatic step();
    logic we; logic [4:0] wa; logic [31:0] wd;
    we = wb_en; wa = wb_addr; wd = wb_data;
    @(posedge clock);
    #1;
    if (!start && we && wa != 5'd0) m_regs[wa] = wd;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
  endtask

  task automatic test_reset();
    clear_model();
    start = 1'b1;
    drive(1, 32'h2109FFFF, 4'h1, 1, 1, 5'd3, 32'h12345678);
    step();
    n_checks++; if (obs() !== out_t'(0)) begin n_fail++; $display("FAIL reset_outputs: got %h, expected 0", obs()); end
    n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL reset_if_ready: got %b, expected 0", if_ready); end
    start = 1'b0;
    drive(0, 0, 0, 1, 0, 0, 0);
    #1;
    n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b, expected 1", if_ready); end
    step();
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid: got %b, expected 0", id_valid); end
  endtask

  task automatic test_addi();
    out_t e;
    drive(0, 0, 0, 1, 1, 5'd8, 32'h5);
    step();
    drive(1, 32'h2109FFFF, 4'h3, 1, 0, 0, 0);
    #1;
    n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL addi_if_ready: got %b, expected 1", if_ready); end
    e = model(if_instr, 4'h3, src(5'd8), src(5'd9));
    step();
    n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL addi_bundle: got %h, expected %h", obs(), e); end
    n_checks++;
    if ({id_rs_data, id_imm, id_dest, id_alu_op, id_reg_write} !== {32'd5, 32'hFFFFFFFF, 5'd9, 2'b00, 1'b1}) begin
      n_fail++; $display("FAIL addi_fields: got rs=%h imm=%h dest=%0d op=%b rw=%b, expected 5/ffffffff/9/00/1",
                         id_rs_data, id_imm, id_dest, id_alu_op, id_reg_write);
    end
    drive(0, 0, 0, 1, 0, 0, 0);
    step();
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain_valid: got %b, expected 0", id_valid); end
  endtask

  task automatic test_load_use();
    out_t e;
    drive(0, 0, 0, 1, 1, 5'd1, 32'h100); step();
    drive(0, 0, 0, 1, 1, 5'd2, 32'h7);   step();
    drive(1, 32'h8C220004, 4'h4, 1, 0, 0, 0);
    #1;
    n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL lw_if_ready: got %b, expected 1", if_ready); end
    e = model(if_instr, 4'h4, src(5'd1), src(5'd2));
    step();
    n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL lw_bundle: got %h, expected %h", obs(), e); end
    drive(1, 32'h00421820, 4'h5, 1, 0, 0, 0);
    #1;
    n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL load_use_stall: got %b, expected 0", if_ready); end
    step();
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL load_use_bubble: got %b, expected 0", id_valid); end
    n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL load_use_resume: got %b, expected 1", if_ready); end
    e = model(if_instr, 4'h5, 32'h7, 32'h7);
    step();
    n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL add_after_bubble: got %h, expected %h", obs(), e); end
    drive(0, 0, 0, 1, 0, 0, 0); step();
  endtask

  task automatic test_stall();
    out_t e;
    drive(0, 0, 0, 1, 1, 5'd5, 32'hAAAA0005); step();
    drive(0, 0, 0, 1, 1, 5'd6, 32'h60);       step();
    drive(1, 32'hACC50008, 4'h6, 1, 0, 0, 0);
    e = model(if_instr, 4'h6, src(5'd6), src(5'd5));
    step();
    n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL sw_bundle: got %h, expected %h", obs(), e); end
    drive(1, 32'h2109FFFF, 4'h7, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL stall_if_ready[%0d]: got %b, expected 0", i, if_ready); end
      step();
      n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL stall_hold[%0d]: got %h, expected %h", i, obs(), e); end
    end
    id_ready = 1'b1;
    #1;
    n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release: got %b, expected 1", if_ready); end
    e = model(if_instr, 4'h7, src(5'd8), src(5'd9));
    step();
    n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL stall_next_instr: got %h, expected %h", obs(), e); end
    drive(0, 0, 0, 1, 0, 0, 0); step();
  endtask

  task automatic test_wb_same_cycle();
    logic [31:0] exp_rs;
    out_t e;
    drive(0, 0, 0, 1, 1, 5'd4, 32'h1111); step();
`ifdef WB_BYPASS_EN
    exp_rs = 32'hDEADBEEF;
`else
    exp_rs = 32'h1111;
`endif
    drive(1, 32'h00803820, 4'h8, 1, 1, 5'd4, 32'hDEADBEEF);
    e = model(if_instr, 4'h8, exp_rs, 32'd0);
    step();
    n_checks++; if (id_rs_data !== exp_rs) begin n_fail++; $display("FAIL wb_same_cycle_rs: got %h, expected %h", id_rs_data, exp_rs); end
    n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL wb_same_cycle_bundle: got %h, expected %h", obs(), e); end
    drive(1, 32'h00000020, 4'h9, 1, 1, 5'd0, 32'hFFFFFFFF);
    step();
    n_checks++; if ({id_rs_data, id_rt_data} !== 64'd0) begin n_fail++; $display("FAIL r0_write_same: got %h/%h, expected 0/0", id_rs_data, id_rt_data); end
    drive(1, 32'h00043820, 4'hA, 1, 0, 0, 0);
    step();
    n_checks++; if ({id_rs_data, id_rt_data} !== {32'd0, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL r0_after_write: got %h/%h, expected 0/deadbeef", id_rs_data, id_rt_data);
    end
    drive(0, 0, 0, 1, 0, 0, 0); step();
  endtask

  task automatic test_halt();
    out_t e;
    drive(1, 32'hFC000000, 4'hB, 1, 0, 0, 0);
    #1;
    n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL halt_accept_ready: got %b, expected 1", if_ready); end
    e = model(if_instr, 4'hB, src(5'd0), src(5'd0));
    step();
    n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL halt_bundle: got %h, expected %h", obs(), e); end
    drive(1, 32'h2109FFFF, 4'hC, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++;
      if ({if_ready, id_end} !== 2'b01) begin
        n_fail++; $display("FAIL halt_stall[%0d]: got if_ready=%b id_end=%b, expected 0/1", i, if_ready, id_end);
      end
      step();
    end
    start = 1'b1;
    #1;
    n_checks++; if (obs() !== out_t'(0)) begin n_fail++; $display("FAIL halt_start_outputs: got %h, expected 0", obs()); end
    n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL halt_start_ready: got %b, expected 0", if_ready); end
    step();
    start = 1'b0;
    clear_model();
    drive(1, 32'h2109FFFF, 4'hC, 1, 0, 0, 0);
    #1;
    n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL halt_resume_ready: got %b, expected 1", if_ready); end
    e = model(if_instr, 4'hC, src(5'd8), src(5'd9));
    step();
    n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL halt_resume_bundle: got %h, expected %h", obs(), e); end
    drive(0, 0, 0, 1, 0, 0, 0); step();
  endtask

  task automatic test_illegal();
    out_t e;
    drive(1, 32'hE8A51234, 4'hD, 1, 0, 0, 0);
    e = model(if_instr, 4'hD, src(5'd5), src(5'd5));
    step();
    n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL illegal_bundle: got %h, expected %h", obs(), e); end
    n_checks++;
    if ({id_valid, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch, id_alu_src,
         id_alu_op, id_illegal, id_end} !== 11'b1_000000_00_1_0) begin
      n_fail++; $display("FAIL illegal_controls: got illegal=%b end=%b rw=%b op=%b, expected 1/0/0/00",
                         id_illegal, id_end, id_reg_write, id_alu_op);
    end
    drive(0, 0, 0, 1, 0, 0, 0); step();
  endtask

  task automatic test_random();
    out_t exp_q, nxt;
    logic [31:0] r, ins;
    logic [5:0] op;
    logic v, rdy, we, hz, er;
    start = 1'b1;
    drive(0, 0, 0, 1, 0, 0, 0);
    step();
    start = 1'b0;
    clear_model();
    exp_q = '0;
    for (int i = 0; i < 400; i++) begin
      r = $urandom();
      case ($urandom_range(0, 6))
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2B;
        3: op = 6'h04;
        4: op = 6'h08;
        5: op = 6'h3A;
        default: begin op = 6'($urandom_range(0, 62)); end
      endcase
      ins = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), r[15:0]};
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      we  = $urandom_range(0, 1) == 1;
      drive(v, ins, 4'(i), rdy, we, 5'($urandom_range(0, 7)), $urandom());
      #1;
      hz = exp_q.valid && exp_q.mem_read && exp_q.dest != 0
           && (ins[25:21] == exp_q.dest || ins[20:16] == exp_q.dest);
      er = (!exp_q.valid || rdy) && !hz;
      n_checks++; if (if_ready !== er) begin n_fail++; $display("FAIL rand_if_ready[%0d]: got %b, expected %b", i, if_ready, er); end
      if (v && er) nxt = model(ins, 4'(i), src(ins[25:21]), src(ins[20:16]));
      else begin
        nxt = exp_q;
        if (rdy) nxt.valid = 1'b0;
      end
      step();
      exp_q = nxt;
      n_checks++; if (obs() !== exp_q) begin n_fail++; $display("FAIL rand_out[%0d]: got %h, expected %h", i, obs(), exp_q); end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_use();
    test_stall();
    test_wb_same_cycle();
    test_halt();
    test_illegal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
